// File: rtl/int_exec_pkg.sv
// Shared definitions for the integer execution slice: widths, opcode map and
// the result-buffer entry layout.
package int_exec_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int OPC_W  = 5;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OPC_W-1:0] OP_SLL  = 5'd2;
  localparam logic [OPC_W-1:0] OP_SLT  = 5'd3;
  localparam logic [OPC_W-1:0] OP_SLTU = 5'd4;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'd5;
  localparam logic [OPC_W-1:0] OP_SRL  = 5'd6;
  localparam logic [OPC_W-1:0] OP_SRA  = 5'd7;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd8;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd9;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'd10;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } result_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_BUSY
  } exec_state_e;

endpackage

// File: rtl/int_alu.sv
// Combinational 32-bit integer ALU for opcodes 0..9. Any other opcode
// (including MUL, which is handled by the caller) yields zero.
module int_alu
  import int_exec_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] result
);

  logic [4:0] shamt;
  assign shamt = rs2_data[4:0];

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = rs1_data + rs2_data;
      OP_SUB:  result = rs1_data - rs2_data;
      OP_SLL:  result = rs1_data << shamt;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(rs1_data) < $signed(rs2_data))};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, (rs1_data < rs2_data)};
      OP_XOR:  result = rs1_data ^ rs2_data;
      OP_SRL:  result = rs1_data >> shamt;
      OP_SRA:  result = $unsigned($signed(rs1_data) >>> shamt);
      OP_OR:   result = rs1_data | rs2_data;
      OP_AND:  result = rs1_data & rs2_data;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/int_exec_issue_unit.sv
// Integer execution unit: accepts the ready reservation-station head, runs a
// single-cycle ALU op or fixed-latency MUL, and drains results to the CDB in order.
module int_exec_issue_unit
  import int_exec_pkg::*;
#(
  parameter int MUL_LAT    = 3,
  parameter int RBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issueque_ready,
  input  logic [DATA_W-1:0] issueque_rs1_data,
  input  logic [DATA_W-1:0] issueque_rs2_data,
  input  logic [TAG_W-1:0]  issueque_rd_tag,
  input  logic [OPC_W-1:0]  issueque_opcode,
  output logic              issueblk_done,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              unit_busy
);

  localparam int CNT_W = $clog2(MUL_LAT);

  exec_state_e   state_reg;
  logic [CNT_W-1:0] mul_cnt_reg;
  result_entry_t mul_entry_reg;
  result_entry_t rbuf_mem [RBUF_DEPTH];
  logic          rd_ptr_reg;
  logic          wr_ptr_reg;
  logic [1:0]    count_reg;

  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mul_product;
  logic [2:0]        slots_used;
  logic              mul_in_flight;
  logic              pop;
  logic              has_slot;
  logic              is_mul;
  logic              accept_mul;
  logic              accept_alu;
  logic              mul_done;
  logic              push;
  result_entry_t     push_entry;
  result_entry_t     head_entry;

  int_alu u_alu (
    .opcode   (issueque_opcode),
    .rs1_data (issueque_rs1_data),
    .rs2_data (issueque_rs2_data),
    .result   (alu_result)
  );

  assign mul_product   = issueque_rs1_data * issueque_rs2_data;
  assign mul_in_flight = (state_reg == ST_MUL_BUSY);
  assign cdb_req       = (count_reg != 2'd0);
  assign pop           = cdb_req & cdb_grant;

  // An in-flight MUL holds a reserved slot so its completion can never stall.
  assign slots_used = {1'b0, count_reg} + {2'b00, mul_in_flight};
  assign has_slot   = (slots_used < 3'(RBUF_DEPTH)) | pop;

  assign issueblk_done = issueque_ready & ~reset & (state_reg == ST_IDLE) & has_slot;
  assign is_mul        = (issueque_opcode == OP_MUL);
  assign accept_mul    = issueblk_done & is_mul;
  assign accept_alu    = issueblk_done & ~is_mul;
  assign mul_done      = mul_in_flight & (mul_cnt_reg == '0);
  assign push          = accept_alu | mul_done;

  always_comb begin
    push_entry      = mul_entry_reg;
    if (!mul_done) begin
      push_entry.tag  = issueque_rd_tag;
      push_entry.data = alu_result;
    end
  end

  assign head_entry = rbuf_mem[rd_ptr_reg];
  assign cdb_tag    = head_entry.tag;
  assign cdb_data   = head_entry.data;
  assign unit_busy  = mul_in_flight;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      mul_cnt_reg   <= '0;
      mul_entry_reg <= '0;
      rd_ptr_reg    <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
      for (int i = 0; i < RBUF_DEPTH; i++) begin
        rbuf_mem[i] <= '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept_mul) begin
            state_reg          <= ST_MUL_BUSY;
            mul_cnt_reg        <= CNT_W'(MUL_LAT - 1);
            mul_entry_reg.tag  <= issueque_rd_tag;
            mul_entry_reg.data <= mul_product;
          end
        end
        ST_MUL_BUSY: begin
          if (mul_cnt_reg == '0) begin
            state_reg <= ST_IDLE;
          end else begin
            mul_cnt_reg <= mul_cnt_reg - 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (push) begin
        rbuf_mem[wr_ptr_reg] <= push_entry;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      // Push and pop together leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule
